// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int DEF_NUM_CONSUMERS = 4;
  localparam int DEF_ADDR_BITS     = 8;
  localparam int DEF_DATA_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    READ_WAIT  = 2'b01,
    WRITE_WAIT = 2'b10,
    RELEASE    = 2'b11
  } arb_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo N.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N = DEF_NUM_CONSUMERS,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(ptr) + i) % N);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_CONSUMERS requesters.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  localparam int IDX_BITS     = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
  output logic                                      mem_read_valid,
  output logic [ADDR_BITS-1:0]                      mem_read_address,
  input  logic                                      mem_read_ready,
  input  logic [DATA_BITS-1:0]                      mem_read_data,
  output logic                                      mem_write_valid,
  output logic [ADDR_BITS-1:0]                      mem_write_address,
  output logic [DATA_BITS-1:0]                      mem_write_data,
  input  logic                                      mem_write_ready
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]                               perf_grant_count,
  output logic [31:0]                               perf_stall_count
`endif
);

  arb_state_t               state;
  logic [IDX_BITS-1:0]      current;
  logic [IDX_BITS-1:0]      pointer;
  logic                     served_read;
  logic [NUM_CONSUMERS-1:0] request;
  logic                     pick_found;
  logic [IDX_BITS-1:0]      pick_index;

  assign request = consumer_read_valid | consumer_write_valid;

  rr_picker #(.N(NUM_CONSUMERS)) u_picker (
    .req   (request),
    .ptr   (pointer),
    .found (pick_found),
    .index (pick_index)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      current              <= '0;
      pointer              <= IDX_BITS'(NUM_CONSUMERS - 1);
      served_read          <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            current <= pick_index;
            pointer <= pick_index;
            if (consumer_read_valid[pick_index]) begin
              served_read      <= 1'b1;
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick_index];
              state            <= READ_WAIT;
            end else begin
              served_read       <= 1'b0;
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick_index];
              mem_write_data    <= consumer_write_data[pick_index];
              state             <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid               <= 1'b0;
            consumer_read_data[current]  <= mem_read_data;
            consumer_read_ready[current] <= 1'b1;
            state                        <= RELEASE;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid               <= 1'b0;
            consumer_write_ready[current] <= 1'b1;
            state                         <= RELEASE;
          end
        end
        // Only the served direction must drop; a still-pending write from the
        // same requester would otherwise never be released and never be granted.
        RELEASE: begin
          if (served_read ? !consumer_read_valid[current] : !consumer_write_valid[current])
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [NUM_CONSUMERS-1:0] current_mask;
  logic                     others_waiting;

  assign current_mask   = NUM_CONSUMERS'(1) << current;
  assign others_waiting = |(request & ~current_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_grant_count <= '0;
      perf_stall_count <= '0;
    end else begin
      if (state == IDLE && pick_found)
        perf_grant_count <= sat_inc(perf_grant_count);
      if (others_waiting)
        perf_stall_count <= sat_inc(perf_stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; counter checks compile in with MEM_ARB_PERF_EN.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic                 clk;
  logic                 reset_n;
  logic [N-1:0]         consumer_read_valid;
  logic [N-1:0][AW-1:0] consumer_read_address;
  logic [N-1:0]         consumer_read_ready;
  logic [N-1:0][DW-1:0] consumer_read_data;
  logic [N-1:0]         consumer_write_valid;
  logic [N-1:0][AW-1:0] consumer_write_address;
  logic [N-1:0][DW-1:0] consumer_write_data;
  logic [N-1:0]         consumer_write_ready;
  logic                 mem_read_valid;
  logic [AW-1:0]        mem_read_address;
  logic                 mem_read_ready;
  logic [DW-1:0]        mem_read_data;
  logic                 mem_write_valid;
  logic [AW-1:0]        mem_write_address;
  logic [DW-1:0]        mem_write_data;
  logic                 mem_write_ready;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]          perf_grant_count;
  logic [31:0]          perf_stall_count;
`endif

  int totalCount = 0;
  int badCount   = 0;
  int hits[N];
  logic [16:0] memLog[$];

  mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_grant_count       (perf_grant_count),
    .perf_stall_count       (perf_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side log: one entry {is_write, address, data} per accepted transfer.
  always @(posedge clk) begin
    if (mem_read_valid && mem_read_ready)
      memLog.push_back({1'b0, mem_read_address, mem_read_data});
    if (mem_write_valid && mem_write_ready)
      memLog.push_back({1'b1, mem_write_address, mem_write_data});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] rv, input logic [N-1:0] wv);
    consumer_read_valid  = rv;
    consumer_write_valid = wv;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  // Behaves like well-mannered requesters: each drops its valid on seeing its ready.
  task automatic serveAll(input int maxCycles);
    int n = 0;
    while (((consumer_read_valid | consumer_write_valid) != '0) && n < maxCycles) begin
      cycle();
      n++;
      for (int i = 0; i < N; i++) begin
        if (consumer_read_ready[i]) begin
          consumer_read_valid[i] = 1'b0;
          hits[i]++;
        end
        if (consumer_write_ready[i]) begin
          consumer_write_valid[i] = 1'b0;
          hits[i]++;
        end
      end
    end
    checkOutput("serve_pending", 32'(consumer_read_valid | consumer_write_valid), 32'd0);
    cycle();
    cycle();
  endtask

  initial begin
    int highCount;
    logic [16:0] expEntry;

    reset_n                = 1'b0;
    consumer_read_address  = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    mem_read_ready         = 1'b0;
    mem_read_data          = '0;
    mem_write_ready        = 1'b0;
    applyStimulus('0, '0);
    doReset();

    checkOutput("rst_mem_valids", 32'({mem_read_valid, mem_write_valid}), 32'd0);
    checkOutput("rst_ready", 32'({consumer_read_ready, consumer_write_ready}), 32'd0);
    checkOutput("rst_read_data", 32'(consumer_read_data), 32'd0);

    // Uncontended read by consumer 2 with a three-cycle memory.
    consumer_read_address[2] = 8'h10;
    mem_read_data            = 8'hAB;
    applyStimulus(4'b0100, 4'b0000);
    cycle();
    checkOutput("A_grant_valid", 32'(mem_read_valid), 32'd1);
    checkOutput("A_grant_addr", 32'(mem_read_address), 32'h10);
    highCount = 1;
    cycle();
    if (mem_read_valid) highCount++;
    cycle();
    if (mem_read_valid) highCount++;
    mem_read_ready = 1'b1;
    cycle();
    mem_read_ready = 1'b0;
    checkOutput("A_valid_cycles", 32'(highCount), 32'd3);
    checkOutput("A_valid_drop", 32'(mem_read_valid), 32'd0);
    checkOutput("A_ready", 32'(consumer_read_ready), 32'b0100);
    checkOutput("A_data", 32'(consumer_read_data[2]), 32'hAB);
    cycle();
    checkOutput("A_ready_once", 32'(consumer_read_ready), 32'd0);
    checkOutput("A_no_reissue", 32'(mem_read_valid), 32'd0);
    applyStimulus(4'b0000, 4'b0000);
    cycle();
    cycle();
    checkOutput("A_data_held", 32'(consumer_read_data[2]), 32'hAB);

    // Reset in READ_WAIT clears outputs at once; consumer 0 then wins first.
    consumer_read_address[0] = 8'h55;
    consumer_read_address[1] = 8'h77;
    applyStimulus(4'b0010, 4'b0000);
    cycle();
    checkOutput("R_pre_addr", 32'(mem_read_address), 32'h77);
    reset_n = 1'b0;
    #1;
    checkOutput("R_async_valid", 32'({mem_read_valid, mem_write_valid}), 32'd0);
    checkOutput("R_async_addr", 32'({mem_read_address, mem_write_address, mem_write_data}), 32'd0);
    checkOutput("R_async_data", 32'(consumer_read_data), 32'd0);
    applyStimulus(4'b0011, 4'b0000);
    cycle();
    reset_n = 1'b1;
    cycle();
    checkOutput("R_first_valid", 32'(mem_read_valid), 32'd1);
    checkOutput("R_first_addr", 32'(mem_read_address), 32'h55);
    applyStimulus(4'b0000, 4'b0000);
    doReset();

    // All four write together against a zero-wait memory.
    for (int i = 0; i < N; i++) begin
      consumer_write_address[i] = 8'(8'h20 + i);
      consumer_write_data[i]    = 8'(8'h40 + i);
      hits[i] = 0;
    end
    memLog.delete();
    mem_write_ready = 1'b1;
    applyStimulus(4'b0000, 4'b1111);
    serveAll(60);
    mem_write_ready = 1'b0;
    checkOutput("B_log_size", 32'(memLog.size()), 32'd4);
    for (int i = 0; i < N; i++) begin
      expEntry = {1'b1, 8'(8'h20 + i), 8'(8'h40 + i)};
      if (i < memLog.size())
        checkOutput($sformatf("B_order_%0d", i), 32'(memLog[i]), 32'(expEntry));
      checkOutput($sformatf("B_ready_once_%0d", i), 32'(hits[i]), 32'd1);
    end

    // Consumer 1 keeps valid two cycles past its ready; consumer 3 waits.
    consumer_read_address[1] = 8'h61;
    consumer_read_address[3] = 8'h63;
    mem_read_data  = 8'h5A;
    mem_read_ready = 1'b1;
    memLog.delete();
    applyStimulus(4'b1010, 4'b0000);
    cycle();
    checkOutput("D_grant1_addr", 32'(mem_read_address), 32'h61);
    cycle();
    checkOutput("D_ready1", 32'(consumer_read_ready), 32'b0010);
    checkOutput("D_data1", 32'(consumer_read_data[1]), 32'h5A);
    cycle();
    checkOutput("D_hold1_valid", 32'(mem_read_valid), 32'd0);
    checkOutput("D_hold1_ready", 32'(consumer_read_ready), 32'd0);
    cycle();
    checkOutput("D_hold2_valid", 32'(mem_read_valid), 32'd0);
    mem_read_data = 8'hC3;
    applyStimulus(4'b1000, 4'b0000);
    cycle();
    checkOutput("D_release_idle", 32'(mem_read_valid), 32'd0);
    cycle();
    checkOutput("D_grant3_valid", 32'(mem_read_valid), 32'd1);
    checkOutput("D_grant3_addr", 32'(mem_read_address), 32'h63);
    cycle();
    checkOutput("D_ready3", 32'(consumer_read_ready), 32'b1000);
    checkOutput("D_data3", 32'(consumer_read_data[3]), 32'hC3);
    checkOutput("D_data1_held", 32'(consumer_read_data[1]), 32'h5A);
    applyStimulus(4'b0000, 4'b0000);
    mem_read_ready = 1'b0;
    cycle();
    cycle();
    checkOutput("D_access_count", 32'(memLog.size()), 32'd2);

    // Consumer 0 reads and writes at once while consumer 1 has a write pending.
    consumer_read_address[0]  = 8'h30;
    consumer_write_address[0] = 8'h50;
    consumer_write_data[0]    = 8'h11;
    consumer_write_address[1] = 8'h41;
    consumer_write_data[1]    = 8'h22;
    mem_read_data   = 8'h99;
    mem_read_ready  = 1'b1;
    mem_write_ready = 1'b1;
    memLog.delete();
    applyStimulus(4'b0001, 4'b0011);
    serveAll(60);
    checkOutput("E_log_size", 32'(memLog.size()), 32'd3);
    if (memLog.size() >= 3) begin
      checkOutput("E_first_0R", 32'(memLog[0]), 32'({1'b0, 8'h30, 8'h99}));
      checkOutput("E_second_1W", 32'(memLog[1]), 32'({1'b1, 8'h41, 8'h22}));
      checkOutput("E_third_0W", 32'(memLog[2]), 32'({1'b1, 8'h50, 8'h11}));
    end
    checkOutput("E_read_data0", 32'(consumer_read_data[0]), 32'h99);

`ifdef MEM_ARB_PERF_EN
    // Three contended reads from consumers 0..2 with one-cycle memory.
    doReset();
    checkOutput("P_rst_counts", perf_grant_count | perf_stall_count, 32'd0);
    mem_read_ready = 1'b1;
    applyStimulus(4'b0111, 4'b0000);
    serveAll(60);
    checkOutput("P_grant_count", perf_grant_count, 32'd3);
    checkOutput("P_stall_count", perf_stall_count, 32'd7);
`endif

    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
